// File: rtl/pixel_array_readout.sv
// Pixel array frame sequencer: erase, expose, single-slope ramp conversion per pixel,
// then row-by-row readout over a valid/ready handshake.
module pixel_array_readout #(
    parameter int BITS          = 8,
    parameter int NROWS         = 2,
    parameter int NCOLS         = 2,
    parameter int ERASE_CYCLES  = 5,
    parameter int EXPOSE_CYCLES = 255
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        START,
    input  logic                        ABORT,
    input  logic [NROWS*NCOLS*BITS-1:0] PIX_LEVEL,
    output logic                        ERASE,
    output logic                        EXPOSE,
    output logic                        CONVERT,
    output logic [NROWS-1:0]            READ,
    output logic [NCOLS*BITS-1:0]       DATA_OUT,
    output logic                        DATA_VALID,
    input  logic                        DATA_READY,
    output logic                        BUSY,
    output logic                        FRAME_DONE
);

    localparam int PHASE_MAX = (ERASE_CYCLES > EXPOSE_CYCLES) ? ERASE_CYCLES : EXPOSE_CYCLES;
    localparam int CW        = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
    localparam int RW        = (NROWS > 1) ? $clog2(NROWS) : 1;

    localparam logic [CW-1:0]   ERASE_LAST  = CW'(ERASE_CYCLES - 1);
    localparam logic [CW-1:0]   EXPOSE_LAST = CW'(EXPOSE_CYCLES - 1);
    localparam logic [RW-1:0]   ROW_LAST    = RW'(NROWS - 1);
    localparam logic [BITS-1:0] RAMP_LAST   = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_READOUT
    } state_t;

    state_t                      state;
    state_t                      state_n;
    logic [CW-1:0]               phase_cnt;
    logic [BITS-1:0]             ramp;
    logic [RW-1:0]               row;
    logic                        frame_done_q;
    logic                        enter_convert;
    logic                        row_xfer;
    logic                        last_xfer;

    logic [NROWS*NCOLS*BITS-1:0] level_p0;
    logic                        trip_p1 [NROWS][NCOLS];
    logic [BITS-1:0]             pix_p1  [NROWS][NCOLS];

    // A comparator trips once the ramp has reached the pixel's sampled level.
    function automatic logic ramp_reached(input logic [BITS-1:0] r, input logic [BITS-1:0] lvl);
        return r >= lvl;
    endfunction

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= S_IDLE;
            phase_cnt    <= '0;
            ramp         <= '0;
            row          <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state <= state_n;
            if (state_n != state || state == S_IDLE) begin
                phase_cnt <= '0;
            end else begin
                phase_cnt <= phase_cnt + 1'b1;
            end
            // The ramp restarts at zero on every entry to CONVERT and after an abort.
            if (state == S_CONVERT && state_n == S_CONVERT) begin
                ramp <= ramp + 1'b1;
            end else begin
                ramp <= '0;
            end
            if (state_n != S_READOUT) begin
                row <= '0;
            end else if (row_xfer) begin
                row <= row + 1'b1;
            end
            frame_done_q <= last_xfer;
        end
    end

    always_comb begin
        state_n    = state;
        ERASE      = 1'b0;
        EXPOSE     = 1'b0;
        CONVERT    = 1'b0;
        DATA_VALID = 1'b0;
        BUSY       = (state != S_IDLE);
        READ       = '0;
        case (state)
            S_IDLE: begin
                if (START) state_n = S_ERASE;
            end
            S_ERASE: begin
                ERASE = 1'b1;
                if (phase_cnt == ERASE_LAST) state_n = S_EXPOSE;
            end
            S_EXPOSE: begin
                EXPOSE = 1'b1;
                if (phase_cnt == EXPOSE_LAST) state_n = S_CONVERT;
            end
            S_CONVERT: begin
                CONVERT = 1'b1;
                if (ramp == RAMP_LAST) state_n = S_READOUT;
            end
            S_READOUT: begin
                DATA_VALID = 1'b1;
                READ[row]  = 1'b1;
                if (DATA_READY && row == ROW_LAST) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        if (ABORT && state != S_IDLE) state_n = S_IDLE;
    end

    assign enter_convert = (state == S_EXPOSE) && (state_n == S_CONVERT);
    assign row_xfer      = (state == S_READOUT) && DATA_READY;
    assign last_xfer     = row_xfer && (row == ROW_LAST) && !ABORT;
    assign FRAME_DONE    = frame_done_q;

    // Stage p0: levels captured on the last EXPOSE cycle; p1: per-pixel ramp conversion.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            level_p0 <= '0;
            for (int r = 0; r < NROWS; r++) begin
                for (int c = 0; c < NCOLS; c++) begin
                    trip_p1[r][c] <= 1'b0;
                    pix_p1[r][c]  <= '0;
                end
            end
        end else if (enter_convert) begin
            level_p0 <= PIX_LEVEL;
            for (int r = 0; r < NROWS; r++) begin
                for (int c = 0; c < NCOLS; c++) begin
                    trip_p1[r][c] <= 1'b0;
                    pix_p1[r][c]  <= '0;
                end
            end
        end else if (state == S_CONVERT) begin
            for (int r = 0; r < NROWS; r++) begin
                for (int c = 0; c < NCOLS; c++) begin
                    if (!trip_p1[r][c]) begin
                        pix_p1[r][c]  <= ramp;
                        trip_p1[r][c] <= ramp_reached(ramp, level_p0[(r*NCOLS + c)*BITS +: BITS]);
                    end
                end
            end
        end
    end

    // Row mux is gated so DATA_OUT rests at zero whenever no row is presented.
    always_comb begin
        DATA_OUT = '0;
        if (state == S_READOUT) begin
            for (int c = 0; c < NCOLS; c++) begin
                DATA_OUT[c*BITS +: BITS] = pix_p1[row][c];
            end
        end
    end

endmodule

// File: tb/tb_pixel_array_readout.sv
// Directed and randomized frames against a timing/value model derived from the frame rules.
module tb_pixel_array_readout;

    localparam int BITS  = 8;
    localparam int NROWS = 2;
    localparam int NCOLS = 2;
    localparam int E     = 5;
    localparam int X     = 10;
    localparam int LAT   = 1 + E + X + (1 << BITS);

    logic                        CLK;
    logic                        RESET;
    logic                        START;
    logic                        ABORT;
    logic [NROWS*NCOLS*BITS-1:0] PIX_LEVEL;
    logic                        ERASE;
    logic                        EXPOSE;
    logic                        CONVERT;
    logic [NROWS-1:0]            READ;
    logic [NCOLS*BITS-1:0]       DATA_OUT;
    logic                        DATA_VALID;
    logic                        DATA_READY;
    logic                        BUSY;
    logic                        FRAME_DONE;

    int checks = 0;
    int errors = 0;

    pixel_array_readout #(
        .BITS(BITS), .NROWS(NROWS), .NCOLS(NCOLS),
        .ERASE_CYCLES(E), .EXPOSE_CYCLES(X)
    ) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .ABORT(ABORT),
        .PIX_LEVEL(PIX_LEVEL), .ERASE(ERASE), .EXPOSE(EXPOSE), .CONVERT(CONVERT),
        .READ(READ), .DATA_OUT(DATA_OUT), .DATA_VALID(DATA_VALID),
        .DATA_READY(DATA_READY), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {ERASE, EXPOSE, CONVERT, DATA_VALID, BUSY, FRAME_DONE, READ}
    function automatic logic [7:0] ctl_now();
        return {ERASE, EXPOSE, CONVERT, DATA_VALID, BUSY, FRAME_DONE, READ};
    endfunction

    // Phase seen in cycle k after the START cycle (k=1 is the first ERASE cycle).
    function automatic logic [7:0] exp_pre(input int k);
        logic er, ex, cv;
        er = (k <= E);
        ex = (k > E) && (k <= E + X);
        cv = (k > E + X);
        return {er, ex, cv, 1'b0, 1'b1, 1'b0, 2'b00};
    endfunction

    function automatic logic [7:0] exp_rd(input int r);
        logic [NROWS-1:0] oh;
        oh    = '0;
        oh[r] = 1'b1;
        return {3'b000, 1'b1, 1'b1, 1'b0, oh};
    endfunction

    task automatic cut(input string name, input int kind);
        if (kind == 2) RESET = 1'b1;
        else           ABORT = 1'b1;
        tick();
        RESET      = 1'b0;
        ABORT      = 1'b0;
        START      = 1'b0;
        DATA_READY = 1'b1;
        chk({name, " cut ctl"}, ctl_now(), 8'h00);
        chk({name, " cut data"}, DATA_OUT, 0);
        tick();
        chk({name, " cut idle"}, ctl_now(), 8'h00);
    endtask

    // One frame: lv driven at START, optionally replaced by lv2 at cycle chg_k; START
    // re-pulsed at st_k; abort (kind 1) or reset (kind 2) at cut_k; stall readout cycles
    // with DATA_READY low before ready goes high (or random ready when rnd_ready).
    task automatic run_frame(input string name, input logic [31:0] lv, input logic [31:0] lv2,
                             input int chg_k, input int st_k, input int cut_k, input int cut_kind,
                             input int stall, input bit rnd_ready);
        logic [31:0] smp;
        int          k;
        int          r;
        int          stall_left;
        bit          rdy;
        smp        = (chg_k != 0 && chg_k <= E + X) ? lv2 : lv;
        PIX_LEVEL  = lv;
        DATA_READY = 1'b1;
        START      = 1'b1;
        tick();
        START = 1'b0;
        for (k = 1; k < LAT; k++) begin
            chk({name, " phase"}, ctl_now(), exp_pre(k));
            START = (k == st_k);
            if (k == chg_k) PIX_LEVEL = lv2;
            if (k == cut_k) begin
                cut(name, cut_kind);
                return;
            end
            tick();
        end
        START      = 1'b0;
        r          = 0;
        stall_left = stall;
        k          = LAT;
        while (r < NROWS && k < LAT + 200) begin
            chk({name, " row ctl"}, ctl_now(), exp_rd(r));
            chk({name, " row data"}, DATA_OUT, smp[r*NCOLS*BITS +: NCOLS*BITS]);
            if (stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end else begin
                rdy = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            end
            DATA_READY = rdy;
            if (k == cut_k) begin
                cut(name, cut_kind);
                return;
            end
            tick();
            k++;
            if (rdy) r++;
        end
        chk({name, " readout timeout"}, (r < NROWS), 0);
        DATA_READY = 1'b1;
        chk({name, " done"}, ctl_now(), 8'b0000_0100);
        chk({name, " done data"}, DATA_OUT, 0);
        tick();
        chk({name, " done pulse"}, ctl_now(), 8'h00);
    endtask

    initial begin
        RESET      = 1'b1;
        START      = 1'b0;
        ABORT      = 1'b0;
        DATA_READY = 1'b1;
        PIX_LEVEL  = '0;
        tick();
        tick();
        chk("reset ctl", ctl_now(), 8'h00);
        chk("reset data", DATA_OUT, 0);
        START = 1'b1;
        tick();
        chk("reset over start", ctl_now(), 8'h00);
        RESET = 1'b0;
        START = 1'b0;
        tick();
        chk("idle", ctl_now(), 8'h00);

        run_frame("basic", 32'h6050_4030, 32'h0, 0, 0, 0, 0, 0, 1'b0);
        run_frame("backpressure", $urandom, 32'h0, 0, 0, 0, 0, 7, 1'b0);
        run_frame("boundary a", 32'hFF00_00FF, 32'h0, 0, 0, 0, 0, 0, 1'b0);
        run_frame("boundary b", 32'h00FF_FF00, 32'h0, 0, 0, 0, 0, 0, 1'b0);
        run_frame("late level change", $urandom, $urandom, 100, 0, 0, 0, 0, 1'b0);
        run_frame("start while busy", $urandom, 32'h0, 0, 8, 0, 0, 0, 1'b0);
        run_frame("abort convert", $urandom, 32'h0, 0, 0, 144, 1, 0, 1'b0);
        run_frame("after abort", $urandom, 32'h0, 0, 0, 0, 0, 0, 1'b0);
        run_frame("reset convert", $urandom, 32'h0, 0, 0, 144, 2, 0, 1'b0);
        run_frame("after reset", $urandom, 32'h0, 0, 0, 0, 0, 0, 1'b0);
        run_frame("abort last row", $urandom, 32'h0, 0, 0, LAT + 1, 1, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_frame("random", $urandom, $urandom, $urandom_range(1, LAT - 1),
                      $urandom_range(1, 20), 0, 0, $urandom_range(0, 5), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
